fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction buffer between the fetch stage and decode. It captures each valid `fetch_data_t` that fetch presents and holds it in a small circular FIFO. Decode drains the FIFO in order while it is not stalled. The block decouples fetch's variable i-bus/translation latency from decode stalls, raises backpressure to fetch when full, and discards all buffered instructions on a pipeline flush (branch redirect or trap/`MRET`).

## Interface
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `flush`  in  1  discard all contents this cycle (driven by `flushall | branch`).
- `dataF`  in  `fetch_data_t`  fetch output; an entry is offered when `dataF.valid` = 1.
- `stall`  in  1  decode cannot accept an instruction this cycle.
- `dataQ`  out  `fetch_data_t`  head entry presented to decode.
- `full`  out  1  FIFO holds `DEPTH` entries; fetch treats this as `stop`.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.

## Operation
- State:
  - `DEPTH` slots of `fetch_data_t` with `valid` stripped, holding `instr`, `pc` and `error`.
  - Head pointer `rd` and tail pointer `wr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - Occupancy `cnt`.
- Pop condition: `pop = (cnt != 0) && !stall && !flush`.
- Push condition: `push = dataF.valid && !flush && ((cnt < DEPTH) || pop)`.
  - When full, an entry is accepted in the same cycle as a pop.
- On push: `slot[wr]` receives `dataF.instr`, `dataF.pc` and `dataF.error`, then `wr` advances by 1.
- On pop: `rd` advances by 1.
- Occupancy update:
  - push only: `cnt` + 1.
  - pop only: `cnt` − 1.
  - push and pop together: `cnt` unchanged.
- Flush:
  - Next edge sets `rd` = `wr` = 0 and `cnt` = 0.
  - The same-cycle `dataF` is dropped; flush has priority over push and pop.
- `dataQ` is combinational from the head:
  - `dataQ.valid = (cnt != 0) && !flush`.
  - `dataQ.instr`, `dataQ.pc` and `dataQ.error` come from `slot[rd]`.
  - These fields are don't-care while `dataQ.valid` = 0.
- Error entries (`INSTR_MISALIGN`) are buffered and delivered exactly like normal entries; the block never interprets `error`.
- `full = (cnt == DEPTH)`, combinational from registered `cnt`.
- `count = cnt`.
- An offered entry that is not accepted (full, no pop) is lost unless fetch holds it. Fetch must hold `pc` while `full` = 1, which it does via `stop`.
- Slot contents are not cleared by reset or flush. Only pointers and count are cleared.

## Timing
- Reset:
  - While `reset` = 0, asynchronously `rd` = `wr` = `cnt` = 0.
  - Outputs: `dataQ.valid` = 0, `full` = 0, `count` = 0.
  - Reset asserted mid-operation clears immediately, with no edge needed.
  - First push possible on the first rising edge after `reset` returns to 1.
- Latency:
  - An entry pushed at edge N appears on `dataQ` (valid) after edge N, in cycle N+1.
  - There is no combinational bypass from `dataF` to `dataQ`.
- Throughput: one push and one pop per cycle sustained. The occupancy stays constant under simultaneous push and pop.
- Empty: no pop occurs. Push while empty makes `cnt` = 1 next cycle.
- Full:
  - `full` = 1 with `stall` = 1: the offered entry is rejected.
  - `full` = 1 with `stall` = 0: pop and push in the same cycle, and `full` stays 1.
- Wrap-around: `wr` and `rd` roll from `DEPTH`−1 to 0, with no gap and no duplicate.
- Flush with `stall` = 0: no pop is counted, and decode must ignore the head, since `dataQ.valid` is forced to 0 that cycle.
- Flush in the same cycle as `dataF.valid`: the entry is dropped. The queue is empty in cycle N+1.

## Test plan
- **Reset:** hold `reset` = 0 mid-stream with `cnt` = 3 -> the same cycle shows `count` = 0, `full` = 0, `dataQ.valid` = 0. After release, push `pc` = 0x80000000, `instr` = 0x00000013 -> `dataQ` shows that entry one cycle later.
- **Fill and backpressure:** `stall` = 1, offer `pc` 0x80000000..0x80000010 (5 entries) -> `count` reaches 4, `full` = 1, and the 5th is rejected. Release `stall` -> entries pop in order 0x80000000..0x8000000C.
- **Full push+pop:** with `full` = 1, set `stall` = 0 and offer `pc` 0x80000010 -> `full` stays 1, the head advances to 0x80000004, and 0x80000010 later emerges 4th.
- **Wrap-around streaming:** 20 consecutive pushes with `stall` = 0 throughout -> `dataQ` delivers all 20 pcs in order, one per cycle, after a 1-cycle latency, and `count` ≤ 1.
- **Flush:** with `cnt` = 3, assert `flush` together with `dataF.valid` (`pc` 0x80000100) -> `dataQ.valid` = 0 that cycle and `count` = 0 next cycle. The next push of `pc` 0x80000200 is the next entry delivered.
- **Error passthrough:** push `pc` 0x80000002 with `error` = `INSTR_MISALIGN` -> `dataQ.error` = `INSTR_MISALIGN` and `dataQ.pc` = 0x80000002.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_pkg / fetch_queue
//
// fetch_pkg holds the fetch-to-decode transfer type shared by fetch, this
// queue and decode.
//
// fetch_queue is the instruction buffer between fetch and decode. It is a
// small circular FIFO that captures every valid entry fetch presents. Decode
// drains it in order whenever it is not stalled. The queue asserts
// backpressure (full) when all slots are occupied, and empties itself on a
// pipeline flush.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low reset (0 = reset)
//   flush   in   discard all buffered entries and the entry offered this cycle
//   dataF   in   fetch output; an entry is offered when dataF.valid = 1
//   stall   in   decode cannot accept the head entry this cycle
//   dataQ   out  head entry for decode (combinational from the head slot)
//   full    out  all DEPTH slots are occupied
//   count   out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        INSTR_MISALIGN   = 2'd1,
        INSTR_ACC_FAULT  = 2'd2,
        INSTR_PAGE_FAULT = 2'd3
    } error_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        error_t      error;
    } fetch_data_t;

endpackage : fetch_pkg

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  fetch_data_t                dataF,
    input  logic                       stall,
    output fetch_data_t                dataQ,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Slot storage; valid is implied by occupancy, so it is not stored.
    logic [31:0] slot_instr [DEPTH];
    logic [31:0] slot_pc    [DEPTH];
    error_t      slot_error [DEPTH];

    logic [PTR_W-1:0] rd;
    logic [PTR_W-1:0] wr;
    logic [CNT_W-1:0] cnt;

    logic empty;
    logic push;
    logic pop;

    assign empty = (cnt == '0);

    // Flush overrides both directions. When full, a push is still accepted
    // if the head leaves in the same cycle, which keeps throughput at one
    // entry per cycle with no bubble at the full boundary.
    assign pop  = !empty && !stall && !flush;
    assign push = dataF.valid && !flush && ((cnt < DEPTH_C) || pop);

    // Pointers and occupancy: the only state cleared by reset or flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wr <= wr + PTR_ONE;
            end
            if (pop) begin
                rd <= rd + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Slot contents are never cleared; stale data behind rd is harmless
    // because dataQ.valid is derived from cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_instr[wr] <= dataF.instr;
            slot_pc[wr]    <= dataF.pc;
            slot_error[wr] <= dataF.error;
        end
    end

    // Head presentation. No bypass from dataF: a freshly pushed entry is
    // visible only after the edge that stored it.
    always_comb begin
        dataQ       = '0;
        dataQ.valid = !empty && !flush;
        dataQ.instr = slot_instr[rd];
        dataQ.pc    = slot_pc[rd];
        dataQ.error = slot_error[rd];
    end

    assign full  = (cnt == DEPTH_C);
    assign count = cnt;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    fetch_data_t dataF;
    logic        stall;
    fetch_data_t dataQ;
    logic        full;
    logic [2:0]  count;

    int checks;
    int failures;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .dataF (dataF),
        .stall (stall),
        .dataQ (dataQ),
        .full  (full),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        vld;
        logic [31:0] pc;
        error_t      err;
        logic        st;
        logic        ev;
        logic [31:0] epc;
        error_t      eerr;
        logic        efull;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    // Instruction word is tied to the pc by a fixed rule so the bench can
    // predict it: pc 0x80000000 carries instr 0x00000013.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc - 32'h7FFF_FFED;
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic fl, input logic vld,
                                input logic [31:0] pc, input error_t err, input logic st,
                                input logic ev, input logic [31:0] epc, input error_t eerr,
                                input logic efull, input logic [2:0] ecnt);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.vld = vld; v.pc = pc; v.err = err; v.st = st;
        v.ev = ev; v.epc = epc; v.eerr = eerr; v.efull = efull; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic vld,
                         input logic [31:0] pc, input error_t err, input logic st);
        reset       = rst_n;
        flush       = fl;
        dataF.valid = vld;
        dataF.pc    = pc;
        dataF.instr = instr_of(pc);
        dataF.error = err;
        stall       = st;
    endtask

    task automatic observe(input string tag, input logic ev, input logic [31:0] epc,
                           input error_t eerr, input logic efull, input logic [2:0] ecnt);
        check({tag, ".valid"}, 32'(dataQ.valid), 32'(ev));
        check({tag, ".count"}, 32'(count), 32'(ecnt));
        check({tag, ".full"},  32'(full), 32'(efull));
        if (ev) begin
            check({tag, ".pc"},    dataQ.pc, epc);
            check({tag, ".instr"}, dataQ.instr, instr_of(epc));
            check({tag, ".error"}, 32'(dataQ.error), 32'(eerr));
        end
    endtask

    localparam error_t EN = ERR_NONE;
    localparam error_t EM = INSTR_MISALIGN;

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, EN, 1'b0);

        //             rst fl  vld pc            err st   ev  epc           eerr full cnt
        // reset held
        vecs.push_back(mk(0, 0, 0, 32'h0,        EN, 0,   0, 32'h0,        EN, 0, 3'd0));
        // build cnt = 3 with decode stalled
        vecs.push_back(mk(1, 0, 1, 32'h80000000, EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 32'h80000004, EN, 1,   1, 32'h80000000, EN, 0, 3'd1));
        vecs.push_back(mk(1, 0, 1, 32'h80000008, EN, 1,   1, 32'h80000000, EN, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 1,   1, 32'h80000000, EN, 0, 3'd3));
        // asynchronous reset mid-stream clears in the same cycle
        vecs.push_back(mk(0, 0, 1, 32'h8000000C, EN, 0,   0, 32'h0,        EN, 0, 3'd0));
        // first push after release, visible one cycle later
        vecs.push_back(mk(1, 0, 1, 32'h80000000, EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 1,   1, 32'h80000000, EN, 0, 3'd1));
        // flush with stall high empties the queue
        vecs.push_back(mk(1, 1, 0, 32'h0,        EN, 1,   0, 32'h0,        EN, 0, 3'd1));
        // fill with stall: 5 offers, the 5th rejected
        vecs.push_back(mk(1, 0, 1, 32'h80000000, EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 32'h80000004, EN, 1,   1, 32'h80000000, EN, 0, 3'd1));
        vecs.push_back(mk(1, 0, 1, 32'h80000008, EN, 1,   1, 32'h80000000, EN, 0, 3'd2));
        vecs.push_back(mk(1, 0, 1, 32'h8000000C, EN, 1,   1, 32'h80000000, EN, 0, 3'd3));
        vecs.push_back(mk(1, 0, 1, 32'h80000010, EN, 1,   1, 32'h80000000, EN, 1, 3'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 1,   1, 32'h80000000, EN, 1, 3'd4));
        // full with stall low: push and pop together, full stays
        vecs.push_back(mk(1, 0, 1, 32'h80000010, EN, 0,   1, 32'h80000000, EN, 1, 3'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 1,   1, 32'h80000004, EN, 1, 3'd4));
        // drain in order; 0x80000010 emerges 4th after 0x80000000
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   1, 32'h80000004, EN, 1, 3'd4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   1, 32'h80000008, EN, 0, 3'd3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   1, 32'h8000000C, EN, 0, 3'd2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   1, 32'h80000010, EN, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   0, 32'h0,        EN, 0, 3'd0));
        // flush with cnt = 3 and a same-cycle offer
        vecs.push_back(mk(1, 0, 1, 32'h80000020, EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 32'h80000024, EN, 1,   1, 32'h80000020, EN, 0, 3'd1));
        vecs.push_back(mk(1, 0, 1, 32'h80000028, EN, 1,   1, 32'h80000020, EN, 0, 3'd2));
        vecs.push_back(mk(1, 1, 1, 32'h80000100, EN, 0,   0, 32'h0,        EN, 0, 3'd3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        vecs.push_back(mk(1, 0, 1, 32'h80000200, EN, 1,   0, 32'h0,        EN, 0, 3'd0));
        // error entry passes through untouched
        vecs.push_back(mk(1, 0, 1, 32'h80000002, EM, 0,   1, 32'h80000200, EN, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   1, 32'h80000002, EM, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        EN, 0,   0, 32'h0,        EN, 0, 3'd0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].vld, vecs[i].pc, vecs[i].err, vecs[i].st);
            #1;
            observe($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eerr,
                    vecs[i].efull, vecs[i].ecnt);
        end

        // Wrap-around streaming: 20 back-to-back pushes with decode free.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, (i < 20), 32'h80001000 + 32'(4 * i), EN, 1'b0);
            #1;
            if (i >= 1 && i <= 20)
                observe($sformatf("stream%0d", i), 1'b1, 32'h80001000 + 32'(4 * (i - 1)),
                        EN, 1'b0, 3'd1);
            else
                observe($sformatf("stream%0d", i), 1'b0, 32'h0, EN, 1'b0, 3'd0);
        end

        // Reset asserted between edges clears without waiting for a clock.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h80002000, EN, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, EN, 1'b1);
        #1;
        observe("pre_rst", 1'b1, 32'h80002000, EN, 1'b0, 3'd1);
        #1;
        reset = 1'b0;
        #1;
        observe("async_rst", 1'b0, 32'h0, EN, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_queue
